// File: rtl/sram_write_checker.sv
// sram_write_checker: checks observed SRAM writes against an expected image, counting
// mismatches, out-of-region writes, duplicate writes and locations left unwritten.
module sram_write_checker #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int REGION_BASE = 0,
    parameter int REGION_SIZE = 76800,
    parameter int MAX_ERR     = 10,
    parameter int REF_LAT     = 1
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              start_i,
    input  logic              finish_i,
    input  logic              mon_we_n_i,
    input  logic [ADDR_W-1:0] mon_address_i,
    input  logic [DATA_W-1:0] mon_write_data_i,
    output logic [ADDR_W-1:0] ref_address_o,
    input  logic [DATA_W-1:0] ref_read_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              halt_o,
    output logic              err_pulse_o,
    output logic [15:0]       mismatch_count_o,
    output logic [15:0]       oor_count_o,
    output logic [15:0]       dup_count_o,
    output logic [ADDR_W-1:0] unwritten_count_o,
    output logic [ADDR_W-1:0] first_err_address_o,
    output logic [DATA_W-1:0] first_err_data_o,
    output logic [DATA_W-1:0] first_err_expected_o
);
    localparam int CW = ADDR_W + 1;
    localparam int IW = $clog2(REGION_SIZE);
    localparam int L  = REF_LAT - 1;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_MON   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_SWEEP = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [CW-1:0] BASE    = CW'(REGION_BASE);
    localparam logic [CW-1:0] SIZE    = CW'(REGION_SIZE);
    localparam logic [CW-1:0] SIZE_M1 = CW'(REGION_SIZE - 1);
    localparam logic [CW-1:0] DRN     = CW'(REF_LAT);

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     off;
    logic              clr, strobe, hit, oor, dup0, dup_fin, dupf, mis, cap, fwd_d, sw_v_d, err_d;
    logic              pv_q [REF_LAT];
    logic [ADDR_W-1:0] pa_q [REF_LAT];
    logic [DATA_W-1:0] pd_q [REF_LAT];
    logic [IW-1:0]     pi_q;
    logic              fwd_q, dp_q, sw_v_q, bit_q, err_q;
    logic              bitmap_q [REGION_SIZE];
    logic              bm_we, bm_wd;
    logic [IW-1:0]     bm_wa, bm_ra;
    logic [15:0]       mm_q, mm_d, oor_q, oor_d, dup_q, dup_d;
    logic [ADDR_W-1:0] unw_q, unw_d, fea_q, fea_d;
    logic [DATA_W-1:0] fed_q, fed_d, fee_q, fee_d;

    function automatic logic [15:0] sat16(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    // Addresses below the base wrap to large offsets, so one compare bounds both ends.
    assign off    = {1'b0, mon_address_i} - BASE;
    assign clr    = start_i && state_q != S_CLEAR;
    assign strobe = state_q == S_MON && !mon_we_n_i && !start_i;
    assign hit    = strobe && off < SIZE;
    assign oor    = strobe && !(off < SIZE);

    assign ref_address_o = hit ? mon_address_i : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                state_d = cnt_q == SIZE_M1 ? S_MON : S_CLEAR;
                cnt_d   = cnt_q == SIZE_M1 ? '0 : cnt_q + 1'b1;
            end
            S_MON: begin
                state_d = finish_i ? S_DRAIN : S_MON;
                cnt_d   = '0;
            end
            S_DRAIN: begin
                state_d = cnt_q == DRN ? S_SWEEP : S_DRAIN;
                cnt_d   = cnt_q == DRN ? '0 : cnt_q + 1'b1;
            end
            S_SWEEP: begin
                state_d = cnt_q == SIZE ? S_DONE : S_SWEEP;
                cnt_d   = cnt_q == SIZE ? cnt_q : cnt_q + 1'b1;
            end
            S_IDLE, S_DONE: state_d = state_q;
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
        end
    end

    // A strobe one cycle behind the same address reads the bit before that write lands.
    assign fwd_d   = hit && pv_q[0] && pi_q == off[IW-1:0];
    assign dup0    = bit_q | fwd_q;
    assign dup_fin = (REF_LAT == 1) ? dup0 : dp_q;
    assign mis     = pv_q[L] && ref_read_data_i != pd_q[L];
    assign dupf    = pv_q[L] && dup_fin;
    assign cap     = mis && mm_q == '0 && !clr;
    assign err_d   = mis && !clr;
    assign sw_v_d  = !clr && state_q == S_SWEEP && cnt_q != SIZE;

    always_comb begin
        mm_d  = clr ? '0 : sat16(mm_q, mis);
        oor_d = clr ? '0 : sat16(oor_q, oor);
        dup_d = clr ? '0 : sat16(dup_q, dupf);
        unw_d = clr ? '0 : (sw_v_q && !bit_q && unw_q != '1) ? unw_q + 1'b1 : unw_q;
        fea_d = clr ? '0 : cap ? pa_q[L] : fea_q;
        fed_d = clr ? '0 : cap ? pd_q[L] : fed_q;
        fee_d = clr ? '0 : cap ? ref_read_data_i : fee_q;
    end

    assign bm_we = state_q == S_CLEAR || pv_q[0];
    assign bm_wa = state_q == S_CLEAR ? cnt_q[IW-1:0] : pi_q;
    assign bm_wd = state_q != S_CLEAR;
    assign bm_ra = state_q == S_SWEEP ? cnt_q[IW-1:0] : off[IW-1:0];

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fwd_q   <= 1'b0;
            dp_q    <= 1'b0;
            sw_v_q  <= 1'b0;
            err_q   <= 1'b0;
            mm_q    <= '0;
            oor_q   <= '0;
            dup_q   <= '0;
            unw_q   <= '0;
            fea_q   <= '0;
            fed_q   <= '0;
            fee_q   <= '0;
            for (int k = 0; k < REF_LAT; k++) pv_q[k] <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_q   <= fwd_d;
            dp_q    <= dup0;
            sw_v_q  <= sw_v_d;
            err_q   <= err_d;
            mm_q    <= mm_d;
            oor_q   <= oor_d;
            dup_q   <= dup_d;
            unw_q   <= unw_d;
            fea_q   <= fea_d;
            fed_q   <= fed_d;
            fee_q   <= fee_d;
            pv_q[0] <= hit;
            for (int k = 1; k < REF_LAT; k++) pv_q[k] <= pv_q[k-1] && !clr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (bm_we) bitmap_q[bm_wa] <= bm_wd;
        bit_q   <= bitmap_q[bm_ra];
        pi_q    <= off[IW-1:0];
        pa_q[0] <= mon_address_i;
        pd_q[0] <= mon_write_data_i;
        for (int k = 1; k < REF_LAT; k++) begin
            pa_q[k] <= pa_q[k-1];
            pd_q[k] <= pd_q[k-1];
        end
    end

    assign busy_o               = state_q == S_CLEAR || state_q == S_DRAIN || state_q == S_SWEEP;
    assign done_o               = state_q == S_DONE;
    assign halt_o               = mm_q >= 16'(MAX_ERR);
    assign err_pulse_o          = err_q;
    assign mismatch_count_o     = mm_q;
    assign oor_count_o          = oor_q;
    assign dup_count_o          = dup_q;
    assign unwritten_count_o    = unw_q;
    assign first_err_address_o  = fea_q;
    assign first_err_data_o     = fed_q;
    assign first_err_expected_o = fee_q;
endmodule

// File: tb/tb_sram_write_checker.sv
// tb_sram_write_checker: directed and randomized write streams against a transaction-level
// model of the checker (written bitmap, counters and first-error capture).
module tb_sram_write_checker;
    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int BASE = 4;
    localparam int SIZE = 8;
    localparam int MAXE = 2;

    logic          clk = 1'b0;
    logic          resetn, start, finish, we_n;
    logic [AW-1:0] addr, ref_addr, unw, fea;
    logic [DW-1:0] wdata, ref_rd, fed, fee;
    logic          busy, done, halt, err_pulse;
    logic [15:0]   mm, oor, dup;

    always #5 clk = ~clk;

    sram_write_checker #(
        .ADDR_W(AW), .DATA_W(DW), .REGION_BASE(BASE), .REGION_SIZE(SIZE),
        .MAX_ERR(MAXE), .REF_LAT(1)
    ) dut (
        .clk_i(clk), .resetn_i(resetn), .start_i(start), .finish_i(finish),
        .mon_we_n_i(we_n), .mon_address_i(addr), .mon_write_data_i(wdata),
        .ref_address_o(ref_addr), .ref_read_data_i(ref_rd),
        .busy_o(busy), .done_o(done), .halt_o(halt), .err_pulse_o(err_pulse),
        .mismatch_count_o(mm), .oor_count_o(oor), .dup_count_o(dup),
        .unwritten_count_o(unw), .first_err_address_o(fea),
        .first_err_data_o(fed), .first_err_expected_o(fee)
    );

    // Expected-image memory with one cycle of read latency.
    logic [DW-1:0] ref_mem [256];
    always @(posedge clk) ref_rd <= ref_mem[ref_addr];

    int            n_vec = 0;
    int            n_miss = 0;
    int            m_mm, m_oor, m_dup;
    bit            wr [256];
    logic [AW-1:0] m_fea;
    logic [DW-1:0] m_fed, m_fee;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_mm = 0; m_oor = 0; m_dup = 0;
        m_fea = '0; m_fed = '0; m_fee = '0;
        for (int i = 0; i < 256; i++) wr[i] = 1'b0;
    endtask

    task automatic model_strobe(input int a, input logic [DW-1:0] d);
        if (a < BASE || a >= BASE + SIZE) m_oor++;
        else begin
            if (d != ref_mem[a]) begin
                if (m_mm == 0) begin
                    m_fea = AW'(a); m_fed = d; m_fee = ref_mem[a];
                end
                m_mm++;
            end
            if (wr[a]) m_dup++;
            wr[a] = 1'b1;
        end
    endtask

    task automatic strobe(input int a, input logic [DW-1:0] d);
        we_n = 1'b0; addr = AW'(a); wdata = d;
        #1;
        check("ref_address", 32'(ref_addr), (a >= BASE && a < BASE + SIZE) ? 32'(a) : 32'd0);
        tick();
        we_n = 1'b1;
        model_strobe(a, d);
    endtask

    task automatic clear_wait();
        model_clear();
        for (int i = 0; i < SIZE; i++) begin
            check("clear_busy", 32'(busy), 32'd1);
            tick();
        end
        check("monitor_idle", 32'({busy, done}), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
        clear_wait();
    endtask

    task automatic finish_run(input bit inj);
        int n, u;
        finish = 1'b1; tick(); finish = 1'b0;
        n = 0;
        if (inj) begin
            we_n = 1'b0; addr = AW'(BASE + SIZE - 1); wdata = 16'h0BAD;
            #1;
            check("drain_ref_address", 32'(ref_addr), 32'd0);
            tick();
            we_n = 1'b1;
            n = 1;
        end
        while (!done && n < 40) begin
            tick();
            n++;
        end
        u = 0;
        for (int a = BASE; a < BASE + SIZE; a++) if (!wr[a]) u++;
        check("done_latency", 32'(n), 32'd11);
        check("done_busy", 32'({done, busy}), 32'b10);
        check("mismatch_count", 32'(mm), 32'(m_mm));
        check("oor_count", 32'(oor), 32'(m_oor));
        check("dup_count", 32'(dup), 32'(m_dup));
        check("unwritten_count", 32'(unw), 32'(u));
        check("halt", 32'(halt), 32'(m_mm >= MAXE));
        check("first_err", {8'h0, fea, fed}, {8'h0, m_fea, m_fed});
        check("first_err_expected", 32'(fee), 32'(m_fee));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'hA000 + 16'(i);
        ref_mem[5] = 16'h1235;
        resetn = 1'b0; start = 1'b0; finish = 1'b0; we_n = 1'b1; addr = '0; wdata = '0;
        model_clear();
        tick(); tick();
        check("reset_flags", 32'({busy, done, halt, err_pulse}), 32'd0);
        check("reset_counts", {mm, oor}, 32'd0);
        check("reset_dup_unw", {8'h0, dup, unw}, 32'd0);
        check("reset_ref_address", 32'(ref_addr), 32'd0);
        resetn = 1'b1;
        tick();

        // Full matching pass.
        do_start();
        check("idle_ref_address", 32'(ref_addr), 32'd0);
        for (int a = BASE; a < BASE + SIZE; a++) strobe(a, ref_mem[a]);
        finish_run(1'b0);

        // Mismatch timing, first-error capture and halt.
        do_start();
        strobe(5, 16'h1234);
        check("err_pulse_t1", 32'(err_pulse), 32'd0);
        tick();
        check("err_pulse_t2", 32'(err_pulse), 32'd1);
        check("mm_after_first", 32'(mm), 32'd1);
        check("first_err_addr", 32'(fea), 32'd5);
        check("first_err_data", {fed, fee}, 32'h12341235);
        check("halt_after_first", 32'(halt), 32'd0);
        tick();
        check("err_pulse_t3", 32'(err_pulse), 32'd0);
        strobe(6, 16'h0000);
        tick();
        check("halt_after_second", 32'({halt, err_pulse}), 32'b11);
        check("first_err_kept", 32'(fea), 32'd5);
        finish_run(1'b0);

        // Out-of-region writes at both edges.
        do_start();
        strobe(3, 16'h0003);
        strobe(12, 16'h000C);
        finish_run(1'b0);

        // Back-to-back duplicate then a later one.
        do_start();
        strobe(7, ref_mem[7]);
        strobe(7, ref_mem[7]);
        repeat (4) tick();
        strobe(7, ref_mem[7]);
        finish_run(1'b0);

        // One location missing, strobe during DRAIN ignored.
        do_start();
        for (int a = BASE; a < BASE + SIZE - 1; a++) strobe(a, ref_mem[a]);
        finish_run(1'b1);

        // Randomized streams.
        for (int r = 0; r < 4; r++) begin
            do_start();
            for (int i = 0; i < 30; i++) begin
                int a;
                logic [DW-1:0] d;
                a = int'($urandom_range(0, 15));
                d = ($urandom_range(0, 9) < 7) ? ref_mem[a] : 16'($urandom);
                strobe(a, d);
                if ($urandom_range(0, 2) == 0) tick();
            end
            finish_run(1'b0);
        end

        // Reset during SWEEP, then Start with Finish.
        do_start();
        strobe(5, 16'h1234);
        finish = 1'b1; tick(); finish = 1'b0;
        repeat (5) tick();
        check("sweep_busy", 32'({busy, done}), 32'b10);
        resetn = 1'b0;
        tick();
        check("midreset_flags", 32'({busy, done, halt, err_pulse}), 32'd0);
        check("midreset_counts", {mm, oor}, 32'd0);
        check("midreset_first", {8'h0, fea, fed}, 32'd0);
        resetn = 1'b1;
        tick();
        check("idle_after_reset", 32'({busy, done}), 32'd0);
        start = 1'b1; finish = 1'b1; tick(); start = 1'b0; finish = 1'b0;
        clear_wait();
        finish_run(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
